mdp3_feed_arbiter: RTL and testbench

- Packet-granular controller between the two redundant MDP3 market-data feeds (A and B, Avalon-ST, 64-bit) and the single MDP3 streamer/packetizer.
- Grants the streamer to one feed per packet with round-robin fairness and never switches mid-packet.
- Holds off the next grant until the streamer signals done. Aborts stalled packets and drops malformed beats.
- Keeps per-feed packet and error counters for the debug register block.

---
 rtl/mdp3_pkg.sv | 27 ++
 rtl/mdp3_feed_stats.sv | 26 ++
 rtl/mdp3_feed_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mdp3_feed_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdp3_pkg.sv
// mdp3_pkg: shared types for the MDP3 feed arbiter.
//   state_t  - arbiter FSM states
//   beat_t   - one Avalon-ST beat (sop, eop, valid, data, empty)
//   DATA_W / EMPTY_W / NUM_FEEDS - datapath widths and feed count
package mdp3_pkg;

  localparam int DATA_W    = 64;
  localparam int EMPTY_W   = 3;
  localparam int NUM_FEEDS = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS,
    ST_ABORT,
    ST_WAIT_DONE,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic               valid;
    logic [DATA_W-1:0]  data;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

endpackage

// File: rtl/mdp3_feed_stats.sv
// mdp3_feed_stats: per-feed debug counters.
//   clk, reset  - clock, synchronous active-high reset
//   inc_pkt     - one completed packet this cycle
//   inc_err     - one dropped/aborted event this cycle
//   pkt_cnt     - completed packets, wraps at 2^32
//   err_cnt     - error events, saturates at 0xFFFF
module mdp3_feed_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_pkt,
  input  logic        inc_err,
  output logic [31:0] pkt_cnt,
  output logic [15:0] err_cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (inc_pkt) pkt_cnt <= pkt_cnt + 32'd1;
      if (inc_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mdp3_feed_arbiter.sv
// mdp3_feed_arbiter: packet-granular round-robin arbiter between the two
// redundant MDP3 feeds (A, B) and the single streamer.
//   clk, reset            - clock, synchronous active-high reset
//   a_* / b_*             - Avalon-ST feed inputs, a_ready/b_ready back
//   s_*                   - Avalon-ST output to streamer, s_ready back
//   s_done                - streamer finished the previous packet
//   grant_b               - owner of the streamer (0 = A, 1 = B)
//   busy                  - FSM not idle
//   pkt_abort             - pulse on the cycle the abort beat transfers
//   pkt_cnt_*, err_cnt_*  - per-feed debug counters
module mdp3_feed_arbiter
  import mdp3_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int DONE_WAIT   = 1,
  parameter int DONE_TO_CYC = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_sop,
  input  logic               a_eop,
  input  logic               a_valid,
  input  logic [DATA_W-1:0]  a_data,
  input  logic [EMPTY_W-1:0] a_empty,
  output logic               a_ready,
  input  logic               b_sop,
  input  logic               b_eop,
  input  logic               b_valid,
  input  logic [DATA_W-1:0]  b_data,
  input  logic [EMPTY_W-1:0] b_empty,
  output logic               b_ready,
  output logic               s_start_packet,
  output logic               s_end_packet,
  output logic               s_valid,
  output logic [DATA_W-1:0]  s_data,
  output logic [EMPTY_W-1:0] s_empty,
  input  logic               s_ready,
  input  logic               s_done,
  output logic               grant_b,
  output logic               busy,
  output logic               pkt_abort,
  output logic [31:0]        pkt_cnt_a,
  output logic [31:0]        pkt_cnt_b,
  output logic [15:0]        err_cnt_a,
  output logic [15:0]        err_cnt_b
);

  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam int DW = $clog2(DONE_TO_CYC + 1);

  state_t  state_q, state_d;
  logic    gnt_q, gnt_d;     // feed owning the streamer (1 = B)
  logic    rr_b_q, rr_b_d;   // last granted feed; reset to B so A wins first
  logic [IW-1:0] idle_q, idle_d;
  logic [DW-1:0] done_q, done_d;

  beat_t [NUM_FEEDS-1:0] feed;
  beat_t                 g;
  logic  [NUM_FEEDS-1:0] cand, junk, rdy, inc_pkt, inc_err;
  logic  [NUM_FEEDS-1:0][31:0] pkt_cnt;
  logic  [NUM_FEEDS-1:0][15:0] err_cnt;

  assign feed[0] = {a_sop, a_eop, a_valid, a_data, a_empty};
  assign feed[1] = {b_sop, b_eop, b_valid, b_data, b_empty};
  assign g       = feed[gnt_q];

  // IDLE classification: a valid beat either opens a packet or is stray
  for (genvar f = 0; f < NUM_FEEDS; f++) begin : g_cls
    assign cand[f] = feed[f].valid &  feed[f].sop;
    assign junk[f] = feed[f].valid & ~feed[f].sop;
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_b_d         = rr_b_q;
    idle_d         = idle_q;
    done_d         = done_q;
    rdy            = '0;
    inc_pkt        = '0;
    inc_err        = '0;
    pkt_abort      = 1'b0;
    s_start_packet = 1'b0;
    s_end_packet   = 1'b0;
    s_valid        = 1'b0;
    s_data         = '0;
    s_empty        = '0;
    unique case (state_q)
      ST_IDLE: begin
        idle_d  = '0;
        done_d  = '0;
        rdy     = junk;
        inc_err = junk;
        if (|cand) begin
          gnt_d   = (&cand) ? ~rr_b_q : cand[1];
          rr_b_d  = gnt_d;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        s_valid        = g.valid;
        s_start_packet = g.sop;
        s_end_packet   = g.eop;
        s_data         = g.data;
        s_empty        = g.empty;
        rdy[gnt_q]     = s_ready;
        if (g.valid && s_ready) begin
          idle_d = '0;
          if (g.eop) begin
            inc_pkt[gnt_q] = 1'b1;
            // a done pulse coinciding with the eop already satisfies the wait
            state_d = (DONE_WAIT != 0 && !s_done) ? ST_WAIT_DONE : ST_IDLE;
          end
        end else if (!g.valid) begin
          // only source starvation counts; streamer backpressure holds
          if (idle_q == IW'(TIMEOUT_CYC - 1)) state_d = ST_ABORT;
          else                               idle_d  = idle_q + 1'b1;
        end
      end
      ST_ABORT: begin
        s_valid      = 1'b1;
        s_end_packet = 1'b1;
        if (s_ready) begin
          pkt_abort      = 1'b1;
          inc_err[gnt_q] = 1'b1;
          state_d        = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        rdy[gnt_q] = 1'b1;
        if (g.valid && g.eop) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (s_done || done_q == DW'(DONE_TO_CYC - 1)) state_d = ST_IDLE;
        else                                           done_d  = done_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // keep stray-beat discard from showing ready while held in reset
    if (reset) rdy = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      rr_b_q  <= 1'b1;
      idle_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_b_q  <= rr_b_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
    end
  end

  for (genvar f = 0; f < NUM_FEEDS; f++) begin : g_stats
    mdp3_feed_stats u_stats (
      .clk     (clk),
      .reset   (reset),
      .inc_pkt (inc_pkt[f]),
      .inc_err (inc_err[f]),
      .pkt_cnt (pkt_cnt[f]),
      .err_cnt (err_cnt[f])
    );
  end

  assign a_ready   = rdy[0];
  assign b_ready   = rdy[1];
  assign grant_b   = gnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign pkt_cnt_a = pkt_cnt[0];
  assign pkt_cnt_b = pkt_cnt[1];
  assign err_cnt_a = err_cnt[0];
  assign err_cnt_b = err_cnt[1];

endmodule

// File: tb/tb_mdp3_feed_arbiter.sv
// tb_mdp3_feed_arbiter: vector table for IDLE arbitration, directed
// sequences for multi-cycle corners, and a randomized run scored against
// a packet-level model (per-feed queues of generated beats).
module tb_mdp3_feed_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, s_ready, s_done;
  logic [1:0]  fv, fsop, feop;
  logic [63:0] fd [2];
  logic [2:0]  fe [2];

  logic        a_ready, b_ready, s_start_packet, s_end_packet, s_valid;
  logic [63:0] s_data;
  logic [2:0]  s_empty;
  logic        grant_b, busy, pkt_abort;
  logic [31:0] pkt_cnt_a, pkt_cnt_b;
  logic [15:0] err_cnt_a, err_cnt_b;

  logic        a_ready0, b_ready0, s_start0, s_end0, s_valid0;
  logic [63:0] s_data0;
  logic [2:0]  s_empty0;
  logic        grant_b0, busy0, pkt_abort0;
  logic [31:0] pkt_cnt_a0, pkt_cnt_b0;
  logic [15:0] err_cnt_a0, err_cnt_b0;

  mdp3_feed_arbiter dut (
    .clk(clk), .reset(reset),
    .a_sop(fsop[0]), .a_eop(feop[0]), .a_valid(fv[0]), .a_data(fd[0]),
    .a_empty(fe[0]), .a_ready(a_ready),
    .b_sop(fsop[1]), .b_eop(feop[1]), .b_valid(fv[1]), .b_data(fd[1]),
    .b_empty(fe[1]), .b_ready(b_ready),
    .s_start_packet(s_start_packet), .s_end_packet(s_end_packet),
    .s_valid(s_valid), .s_data(s_data), .s_empty(s_empty),
    .s_ready(s_ready), .s_done(s_done), .grant_b(grant_b), .busy(busy),
    .pkt_abort(pkt_abort), .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b),
    .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b)
  );

  mdp3_feed_arbiter #(.DONE_WAIT(0)) dut0 (
    .clk(clk), .reset(reset),
    .a_sop(fsop[0]), .a_eop(feop[0]), .a_valid(fv[0]), .a_data(fd[0]),
    .a_empty(fe[0]), .a_ready(a_ready0),
    .b_sop(fsop[1]), .b_eop(feop[1]), .b_valid(fv[1]), .b_data(fd[1]),
    .b_empty(fe[1]), .b_ready(b_ready0),
    .s_start_packet(s_start0), .s_end_packet(s_end0),
    .s_valid(s_valid0), .s_data(s_data0), .s_empty(s_empty0),
    .s_ready(s_ready), .s_done(s_done), .grant_b(grant_b0), .busy(busy0),
    .pkt_abort(pkt_abort0), .pkt_cnt_a(pkt_cnt_a0), .pkt_cnt_b(pkt_cnt_b0),
    .err_cnt_a(err_cnt_a0), .err_cnt_b(err_cnt_b0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input int f, input logic v, input logic s, input logic e,
                       input logic [63:0] d, input logic [2:0] em);
    fv[f] = v; fsop[f] = s; feop[f] = e; fd[f] = d; fe[f] = em;
  endtask

  task automatic rst();
    reset = 1'b1; s_ready = 1'b0; s_done = 1'b0;
    drive(0, 0, 0, 0, 64'd0, 3'd0);
    drive(1, 0, 0, 0, 64'd0, 3'd0);
    nxt(); nxt();
    reset = 1'b0;
  endtask

  function automatic logic frdy(input int f);
    return (f == 0) ? a_ready : b_ready;
  endfunction

  // present beats first..n-1 of a packet on feed f; the feed must already be
  // granted and s_ready high. Last beat carries empty = 2.
  task automatic pass_beats(input int f, input int first, input int n, input logic [63:0] base);
    for (int i = first; i < n; i++) begin
      drive(f, 1, i == 0, i == n - 1, base + 64'(i), (i == n - 1) ? 3'd2 : 3'd0);
      smp();
      chk("pass_valid", s_valid, 1);
      chk("pass_data", s_data, base + 64'(i));
      chk("pass_sop", s_start_packet, i == 0);
      chk("pass_eop", s_end_packet, i == n - 1);
      chk("pass_empty", s_empty, (i == n - 1) ? 3'd2 : 3'd0);
      chk("pass_grant", grant_b, f);
      chk("pass_ready", frdy(f), 1);
      chk("pass_other_ready", frdy(1 - f), 0);
      nxt();
    end
    drive(f, 0, 0, 0, 64'd0, 3'd0);
  endtask

  typedef struct {
    logic av, as_, bv, bs;
    logic ar, br, bsy, gb;
    logic [15:0] ea, eb;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [2:0]  e;
    logic        sop, eop;
  } xb_t;

  vec_t tbl [9];
  xb_t  sq0 [$];
  xb_t  sq1 [$];

  initial begin
    int bad, cnt;
    int act [2], len [2], idx [2], gap [2];
    logic [63:0] cur_d [2][4];
    logic [2:0]  cur_e [2];
    int model_pkt [2];
    logic owner, in_pkt, gen;
    xb_t x;

    //            av as bv bs | ar br busy gb | ea eb
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0};
    tbl[1] = '{1, 1, 0, 0, 0, 0, 1, 0, 16'd0, 16'd0};
    tbl[2] = '{0, 0, 1, 1, 0, 0, 1, 1, 16'd0, 16'd0};
    tbl[3] = '{1, 1, 1, 1, 0, 0, 1, 0, 16'd0, 16'd0};
    tbl[4] = '{1, 0, 0, 0, 1, 0, 0, 0, 16'd1, 16'd0};
    tbl[5] = '{0, 0, 1, 0, 0, 1, 0, 0, 16'd0, 16'd1};
    tbl[6] = '{1, 0, 1, 0, 1, 1, 0, 0, 16'd1, 16'd1};
    tbl[7] = '{1, 1, 1, 0, 0, 1, 1, 0, 16'd0, 16'd1};
    tbl[8] = '{1, 0, 1, 1, 1, 0, 1, 1, 16'd1, 16'd0};

    // reset state
    rst();
    smp();
    chk("rst_s_valid", s_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_b", grant_b, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_pkt_abort", pkt_abort, 0);
    chk("rst_pkt_cnt_a", pkt_cnt_a, 0);
    chk("rst_err_cnt_b", err_cnt_b, 0);

    // IDLE arbitration / stray-beat table, each from a fresh reset
    for (int v = 0; v < 9; v++) begin
      rst();
      drive(0, tbl[v].av, tbl[v].as_, 0, 64'h1, 3'd0);
      drive(1, tbl[v].bv, tbl[v].bs, 0, 64'h2, 3'd0);
      smp();
      chk($sformatf("tbl%0d_a_ready", v), a_ready, tbl[v].ar);
      chk($sformatf("tbl%0d_b_ready", v), b_ready, tbl[v].br);
      chk($sformatf("tbl%0d_s_valid", v), s_valid, 0);
      nxt();
      smp();
      chk($sformatf("tbl%0d_busy", v), busy, tbl[v].bsy);
      chk($sformatf("tbl%0d_grant_b", v), grant_b, tbl[v].gb);
      chk($sformatf("tbl%0d_err_a", v), err_cnt_a, tbl[v].ea);
      chk($sformatf("tbl%0d_err_b", v), err_cnt_b, tbl[v].eb);
    end

    // both feeds open together: A first, wait for done, then B
    rst();
    s_ready = 1'b1;
    drive(0, 1, 1, 0, 64'hA000, 3'd0);
    drive(1, 1, 1, 0, 64'hB000, 3'd0);
    smp();
    chk("rr_idle_a_ready", a_ready, 0);
    chk("rr_idle_b_ready", b_ready, 0);
    nxt();
    pass_beats(0, 0, 3, 64'hA000);
    smp();
    chk("rr_wd_busy", busy, 1);
    chk("rr_wd_s_valid", s_valid, 0);
    chk("rr_wd_b_ready", b_ready, 0);
    chk("rr_pkt_a", pkt_cnt_a, 1);
    nxt(); nxt();
    s_done = 1'b1;
    nxt();
    s_done = 1'b0;
    smp();
    chk("rr_idle_after_done", busy, 0);
    nxt();
    pass_beats(1, 0, 3, 64'hB000);
    s_done = 1'b1;
    nxt();
    s_done = 1'b0;
    smp();
    chk("rr_final_pkt_a", pkt_cnt_a, 1);
    chk("rr_final_pkt_b", pkt_cnt_b, 1);
    chk("rr_final_busy", busy, 0);

    // single-beat packet, no done wait (dut0)
    rst();
    s_ready = 1'b1;
    drive(0, 1, 1, 1, 64'h5151, 3'd5);
    nxt();
    smp();
    chk("sb_valid", s_valid0, 1);
    chk("sb_sop", s_start0, 1);
    chk("sb_eop", s_end0, 1);
    chk("sb_empty", s_empty0, 5);
    chk("sb_data", s_data0, 64'h5151);
    nxt();
    drive(0, 0, 0, 0, 64'd0, 3'd0);
    smp();
    chk("sb_busy_after", busy0, 0);
    chk("sb_pkt_a", pkt_cnt_a0, 1);

    // starvation timeout: abort beat, flush rest of A, then B
    rst();
    s_ready = 1'b1;
    drive(0, 1, 1, 0, 64'hC000, 3'd0);
    drive(1, 1, 1, 0, 64'hD000, 3'd0);
    nxt();
    smp();
    chk("to_beat0", s_data, 64'hC000);
    nxt();
    drive(0, 0, 0, 0, 64'd0, 3'd0);
    bad = 0;
    for (int k = 0; k < 1024; k++) begin
      smp();
      if (s_valid || pkt_abort || !busy) bad++;
      nxt();
    end
    chk("to_quiet_1024", bad, 0);
    smp();
    chk("abort_valid", s_valid, 1);
    chk("abort_eop", s_end_packet, 1);
    chk("abort_sop", s_start_packet, 0);
    chk("abort_data", s_data, 0);
    chk("abort_empty", s_empty, 0);
    chk("abort_pulse", pkt_abort, 1);
    nxt();
    smp();
    chk("abort_err_a", err_cnt_a, 1);
    chk("abort_pulse_off", pkt_abort, 0);
    for (int i = 1; i < 3; i++) begin
      drive(0, 1, 0, i == 2, 64'hC000 + 64'(i), 3'd0);
      smp();
      chk("flush_a_ready", a_ready, 1);
      chk("flush_s_valid", s_valid, 0);
      chk("flush_b_ready", b_ready, 0);
      nxt();
    end
    drive(0, 0, 0, 0, 64'd0, 3'd0);
    smp();
    chk("flush_idle", busy, 0);
    nxt();
    pass_beats(1, 0, 3, 64'hD000);
    chk("abort_pkt_a", pkt_cnt_a, 0);
    chk("abort_pkt_b", pkt_cnt_b, 1);

    // long backpressure, then done timeout, then reset mid-packet
    rst();
    s_ready = 1'b1;
    drive(0, 1, 1, 0, 64'hE000, 3'd0);
    nxt();
    smp();
    chk("bp_beat0", s_data, 64'hE000);
    nxt();
    s_ready = 1'b0;
    drive(0, 1, 0, 0, 64'hE001, 3'd0);
    bad = 0;
    for (int k = 0; k < 5000; k++) begin
      smp();
      if (!s_valid || a_ready || pkt_abort || !busy) bad++;
      nxt();
    end
    chk("bp_hold_5000", bad, 0);
    s_ready = 1'b1;
    drive(1, 1, 1, 0, 64'hF000, 3'd0);
    pass_beats(0, 1, 3, 64'hE000);
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      smp();
      if (!busy) break;
      cnt++;
      nxt();
    end
    chk("done_to_cycles", cnt, 256);
    chk("done_to_pkt_a", pkt_cnt_a, 1);
    nxt();
    smp();
    chk("done_to_grant_b", grant_b, 1);
    chk("done_to_busy", busy, 1);
    chk("done_to_b_data", s_data, 64'hF000);
    nxt();
    drive(1, 1, 0, 0, 64'hF001, 3'd0);
    reset = 1'b1;
    nxt();
    smp();
    chk("mid_rst_s_valid", s_valid, 0);
    chk("mid_rst_s_eop", s_end_packet, 0);
    chk("mid_rst_s_data", s_data, 0);
    chk("mid_rst_b_ready", b_ready, 0);
    chk("mid_rst_grant_b", grant_b, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pkt_a", pkt_cnt_a, 0);
    nxt();
    reset = 1'b0;
    drive(1, 0, 0, 0, 64'd0, 3'd0);

    // stray beats on B until the error counter saturates
    rst();
    drive(1, 1, 0, 0, 64'h77, 3'd0);
    smp();
    chk("stray_b_ready", b_ready, 1);
    chk("stray_s_valid", s_valid, 0);
    nxt();
    smp();
    chk("stray_err_b_1", err_cnt_b, 1);
    for (int k = 1; k < 70000; k++) nxt();
    smp();
    chk("stray_err_b_sat", err_cnt_b, 16'hFFFF);
    chk("stray_err_a", err_cnt_a, 0);
    chk("stray_pkt_b", pkt_cnt_b, 0);
    nxt();
    drive(1, 0, 0, 0, 64'd0, 3'd0);

    // randomized traffic against per-feed packet queues
    rst();
    gen = 1'b1; owner = 1'b0; in_pkt = 1'b0;
    for (int f = 0; f < 2; f++) begin
      act[f] = 0; len[f] = 0; idx[f] = 0; gap[f] = 0; model_pkt[f] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) gen = 1'b0;
      s_ready = ($urandom_range(3) != 0);
      s_done  = ($urandom_range(7) == 0);
      for (int f = 0; f < 2; f++) begin
        if (act[f] == 0 && gap[f] > 0) gap[f]--;
        else if (act[f] == 0 && gen) begin
          len[f] = $urandom_range(1, 4);
          idx[f] = 0;
          act[f] = 1;
          cur_e[f] = 3'($urandom_range(7));
          for (int i = 0; i < len[f]; i++) begin
            cur_d[f][i] = {$urandom, $urandom};
            x.d = cur_d[f][i];
            x.sop = (i == 0);
            x.eop = (i == len[f] - 1);
            x.e = x.eop ? cur_e[f] : 3'd0;
            if (f == 0) sq0.push_back(x); else sq1.push_back(x);
          end
        end
        if (act[f] != 0 && $urandom_range(5) != 0)
          drive(f, 1, idx[f] == 0, idx[f] == len[f] - 1, cur_d[f][idx[f]],
                (idx[f] == len[f] - 1) ? cur_e[f] : 3'd0);
        else
          drive(f, 0, 0, 0, 64'd0, 3'd0);
      end
      smp();
      for (int f = 0; f < 2; f++) begin
        if (fv[f] && frdy(f)) begin
          idx[f]++;
          if (idx[f] == len[f]) begin
            act[f] = 0;
            gap[f] = $urandom_range(2);
          end
        end
      end
      if (s_valid && s_ready) begin
        if ((grant_b ? sq1.size() : sq0.size()) == 0)
          chk("rnd_unexpected_beat", grant_b ? sq1.size() : sq0.size(), 1);
        else begin
          x = grant_b ? sq1.pop_front() : sq0.pop_front();
          chk("rnd_data", s_data, x.d);
          chk("rnd_ctrl", {s_start_packet, s_end_packet, s_empty}, {x.sop, x.eop, x.e});
        end
        if (in_pkt) chk("rnd_no_interleave", grant_b, owner);
        owner  = grant_b;
        in_pkt = !s_end_packet;
        if (s_end_packet) model_pkt[grant_b]++;
      end
      if (!gen && act[0] == 0 && act[1] == 0 && sq0.size() == 0 && sq1.size() == 0) break;
      nxt();
    end
    nxt();
    drive(0, 0, 0, 0, 64'd0, 3'd0);
    drive(1, 0, 0, 0, 64'd0, 3'd0);
    s_done = 1'b1;
    nxt(); nxt();
    s_done = 1'b0;
    smp();
    chk("rnd_drain_a", sq0.size(), 0);
    chk("rnd_drain_b", sq1.size(), 0);
    chk("rnd_pkt_a", pkt_cnt_a, 64'(model_pkt[0]));
    chk("rnd_pkt_b", pkt_cnt_b, 64'(model_pkt[1]));
    chk("rnd_err_a", err_cnt_a, 0);
    chk("rnd_err_b", err_cnt_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
